// File: rtl/fetch_ctrl.sv
// PC sequencing and instruction fetch controller: IDLE/FETCH/ISSUE/EXEC/HALT.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDR_SIZE      = 14,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] pc_cur,
    output logic [1:0]           pc_sel,
    output logic [WORD_SIZE-1:0] pc_load,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] ir,
    output logic                 ir_valid,
    input  logic                 ex_ready,
    input  logic                 ex_done,
    input  logic                 br_taken,
    input  logic [WORD_SIZE-1:0] br_target,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 halted,
    output logic [WORD_SIZE-1:0] instr_count,
    output logic                 fetch_err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t               state_r, state_next_s;
    logic [WORD_SIZE-1:0] ir_r;
    logic [WORD_SIZE-1:0] count_r;
    logic [1:0]           pc_sel_s;
    logic                 imem_req_s, ir_valid_s, halted_s;
    logic                 load_ir_s, retire_s, timeout_s;
    logic                 unused_s;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_r;
    logic             err_r;

    assign timeout_s = (state_r == ST_FETCH) && !imem_ack &&
                       (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts ack-less FETCH cycles, cleared outside FETCH; error is sticky until rst
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= '0;
            err_r     <= 1'b0;
        end else if (state_r == ST_FETCH && !imem_ack) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            err_r     <= err_r | timeout_s;
        end else begin
            tmo_cnt_r <= '0;
            err_r     <= err_r;
        end
    end

    assign fetch_err = err_r;
`else
    assign timeout_s = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign unused_s = ^{pc_cur[WORD_SIZE-1:ADDR_SIZE]} ^ (TIMEOUT_CYCLES == 0);

    // Next-state and handshake decode; rst suppresses all requests and PC updates
    always_comb begin
        state_next_s = state_r;
        pc_sel_s     = 2'd1;
        imem_req_s   = 1'b0;
        ir_valid_s   = 1'b0;
        halted_s     = 1'b0;
        load_ir_s    = 1'b0;
        retire_s     = 1'b0;
        if (rst) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = halt_req ? ST_HALT : ST_FETCH;
                end
                ST_FETCH: begin
                    imem_req_s = 1'b1;
                    if (imem_ack) begin
                        load_ir_s    = 1'b1;
                        state_next_s = ST_ISSUE;
                    end else if (timeout_s) begin
                        state_next_s = ST_HALT;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_ISSUE: begin
                    ir_valid_s   = 1'b1;
                    state_next_s = ex_ready ? ST_EXEC : ST_ISSUE;
                end
                ST_EXEC: begin
                    if (ex_done) begin
                        retire_s     = 1'b1;
                        pc_sel_s     = br_taken ? 2'd2 : 2'd0;
                        state_next_s = halt_req ? ST_HALT : ST_FETCH;
                    end else begin
                        state_next_s = ST_EXEC;
                    end
                end
                ST_HALT: begin
                    halted_s = 1'b1;
                    if (resume && !halt_req && !fetch_err) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_HALT;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, instruction register and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ir_r    <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_next_s;
            if (load_ir_s) begin
                ir_r <= imem_rdata;
            end
            if (retire_s) begin
                count_r <= count_r + {{(WORD_SIZE-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pc_sel      = pc_sel_s;
    assign pc_load     = br_target;
    assign imem_req    = imem_req_s;
    assign imem_addr   = pc_cur[ADDR_SIZE-1:0];
    assign ir          = ir_r;
    assign ir_valid    = ir_valid_s;
    assign halted      = halted_s;
    assign instr_count = count_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: PC and memory models, queue of expected issued words.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_cur;
    logic [1:0]  pc_sel;
    logic [31:0] pc_load;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ex_ready = 1'b1;
    logic        ex_done = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        halted;
    logic [31:0] instr_count;
    logic        fetch_err;

    int          tests = 0;
    int          fails = 0;
    int          sel0_cnt = 0;
    int          ack_delay = 2;
    logic        ack_en = 1'b1;
    logic [31:0] exp_q[$];
    logic [31:0] pc_r;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_sel(pc_sel), .pc_load(pc_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid), .ex_ready(ex_ready),
        .ex_done(ex_done), .br_taken(br_taken), .br_target(br_target),
        .halt_req(halt_req), .resume(resume), .halted(halted),
        .instr_count(instr_count), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // PC register: +1 on next, load on 2, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) pc_r <= 32'h0;
        else if (pc_sel == 2'd0) pc_r <= pc_r + 32'd1;
        else if (pc_sel == 2'd2) pc_r <= pc_load;
        else pc_r <= pc_r;
    end
    assign pc_cur     = pc_r;
    assign imem_rdata = {16'hC0DE, 2'b00, imem_addr};

    // Memory responder: ack on the (ack_delay+1)-th request cycle
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req && ack_en) begin
                imem_ack = (wcnt == ack_delay);
                wcnt++;
            end else begin
                imem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ISSUE handshake pops the scoreboard
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && pc_sel == 2'd0) sel0_cnt++;
            if (!rst && ir_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL ir_handshake: got %h with empty scoreboard", ir);
                end else begin
                    e = exp_q.pop_front();
                    check("ir_handshake", ir, e);
                end
            end
        end
    end

    task automatic wait_on(input int which, input logic [31:0] n, input string name);
        int   cyc;
        logic hit;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 200) begin
            @(negedge clk);
            cyc++;
            case (which)
                0:       hit = ir_valid && ex_ready;
                1:       hit = ir_valid;
                2:       hit = imem_req;
                3:       hit = halted;
                default: hit = (instr_count == n);
            endcase
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL wait_%s: not reached within %0d cycles", name, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        @(negedge clk);
        check("rst_ir_valid", 32'(ir_valid), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_pc_sel", 32'(pc_sel), 32'h1);
        check("rst_count", instr_count, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'h0);

        // sequential run of three instructions, halting after the third
        exp_q.push_back(32'hC0DE_0000);
        exp_q.push_back(32'hC0DE_0001);
        exp_q.push_back(32'hC0DE_0002);
        tick();
        rst = 1'b0;
        wait_on(4, 32'd2, "count2");
        tick();
        halt_req = 1'b1;
        wait_on(3, 32'd0, "halt1");
        check("seq_count", instr_count, 32'd3);
        check("seq_pc", pc_cur, 32'd3);
        check("seq_sel0", 32'(sel0_cnt), 32'd3);
        check("halt_imem_req", 32'(imem_req), 32'h0);
        check("halt_pc_sel", 32'(pc_sel), 32'h1);

        // resume blocked while halt_req is held, then released
        tick();
        resume = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h40;
        exp_q.push_back(32'hC0DE_0003);
        repeat (3) @(negedge clk);
        check("resume_conflict_halted", 32'(halted), 32'h1);
        check("resume_conflict_pc", pc_cur, 32'd3);
        tick();
        halt_req = 1'b0;
        @(negedge clk);
        check("resume_edge_halted", 32'(halted), 32'h1);
        tick();
        resume = 1'b0;
        @(negedge clk);
        check("resume_fetch_req", 32'(imem_req), 32'h1);
        check("resume_fetch_addr", 32'(imem_addr), 32'd3);

        // branch redirect on ex_done
        wait_on(0, 32'd0, "issue3");
        @(negedge clk);
        check("br_pc_sel", 32'(pc_sel), 32'd2);
        check("br_pc_load", pc_load, 32'h40);
        tick();
        br_taken = 1'b0;
        ex_ready = 1'b0;
        exp_q.push_back(32'hC0DE_0040);
        @(negedge clk);
        check("br_fetch_addr", 32'(imem_addr), 32'h40);

        // backpressure: ISSUE held for five cycles
        wait_on(1, 32'd0, "issue40");
        for (int i = 0; i < 5; i++) begin
            check("bp_ir_valid", 32'(ir_valid), 32'h1);
            check("bp_ir", ir, 32'hC0DE_0040);
            check("bp_pc_sel", 32'(pc_sel), 32'h1);
            check("bp_imem_req", 32'(imem_req), 32'h0);
            if (i < 4) @(negedge clk);
        end
        tick();
        ex_ready = 1'b1;
        wait_on(2, 32'd0, "fetch41");
        check("pre_rst_count", instr_count, 32'd5);
        check("pre_rst_addr", 32'(imem_addr), 32'h41);

        // reset mid-FETCH
        tick();
        rst = 1'b1;
        ex_ready = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstf_ir_valid", 32'(ir_valid), 32'h0);
        check("rstf_imem_req", 32'(imem_req), 32'h0);
        check("rstf_count", instr_count, 32'h0);
        check("rstf_pc_sel", 32'(pc_sel), 32'h1);
        @(negedge clk);
        check("rstf_refetch_req", 32'(imem_req), 32'h1);
        check("rstf_refetch_addr", 32'(imem_addr), 32'h0);

        // reset mid-ISSUE, then straight to HALT from IDLE
        wait_on(1, 32'd0, "issue0");
        check("rsti_ir_before", ir, 32'hC0DE_0000);
        tick();
        rst = 1'b1;
        halt_req = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rsti_ir_valid", 32'(ir_valid), 32'h0);
        check("rsti_ir", ir, 32'h0);
        check("rsti_count", instr_count, 32'h0);
        @(negedge clk);
        check("idle_to_halt", 32'(halted), 32'h1);
        check("idle_halt_pc", pc_cur, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        // watchdog expiry with no ack
        tick();
        rst = 1'b1;
        halt_req = 1'b0;
        ack_en = 1'b0;
        ex_ready = 1'b1;
        tick();
        rst = 1'b0;
        wait_on(2, 32'd0, "tmo_fetch");
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            check("tmo_req_held", 32'(imem_req), 32'h1);
        end
        check("tmo_err_before", 32'(fetch_err), 32'h0);
        @(negedge clk);
        check("tmo_err", 32'(fetch_err), 32'h1);
        check("tmo_halted", 32'(halted), 32'h1);
        check("tmo_req_drop", 32'(imem_req), 32'h0);
        tick();
        resume = 1'b1;
        repeat (3) @(negedge clk);
        check("tmo_resume_ignored", 32'(halted), 32'h1);
        check("tmo_err_sticky", 32'(fetch_err), 32'h1);

        // ack on the limit cycle wins
        tick();
        resume = 1'b0;
        rst = 1'b1;
        ack_en = 1'b1;
        ack_delay = 15;
        exp_q.push_back(32'hC0DE_0000);
        exp_q.push_back(32'hC0DE_0001);
        tick();
        rst = 1'b0;
        wait_on(4, 32'd1, "tmo_count1");
        tick();
        halt_req = 1'b1;
        wait_on(3, 32'd0, "tmo_halt2");
        check("tmo_ack_err", 32'(fetch_err), 32'h0);
        check("tmo_ack_count", instr_count, 32'd2);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
